uop_issue_queue: RTL

- Frontend-side producer for the backend uop-issue interface: `uop_ready`, `uop`, `eoi`, `imm`, `use_imm`, `pc`, `except`, `src1_arch`, `src2_arch`, `dest_arch`.
- Buffers decoded uops from the decoder in an in-order FIFO and presents the head entry to `backend_TOP`.
- The backend throttles issue through a stall input.
- Handles pipeline flush and reports how many complete instructions (uops with `eoi` set) are buffered.

---
 rtl/uop_pkg.sv | 36 +++
 rtl/uop_fifo_mem.sv | 25 ++
 rtl/uop_issue_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uop_pkg.sv
// Shared uop-issue definitions: field widths, entry layout and
// pack/unpack helpers used by the issue queue and the backend.
package uop_pkg;

    localparam int UOP_W     = 7;
    localparam int REG_IDX_W = 4;
    localparam int XLEN      = 32;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic [UOP_W-1:0]     uop;
        logic                 eoi;
        logic [XLEN-1:0]      imm;
        logic                 use_imm;
        logic [PC_W-1:0]      pc;
        logic                 except;
        logic [REG_IDX_W-1:0] src1_arch;
        logic [REG_IDX_W-1:0] src2_arch;
        logic [REG_IDX_W-1:0] dest_arch;
    } uop_entry_t;

    localparam int ENTRY_W = $bits(uop_entry_t);

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input uop_entry_t e
    );
        return e;
    endfunction

    function automatic uop_entry_t unpack_entry(
        input logic [ENTRY_W-1:0] b
    );
        return b;
    endfunction

endpackage

// File: rtl/uop_fifo_mem.sv
// Issue-queue storage: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module uop_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 86
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uop_issue_queue.sv
// In-order uop FIFO between decoder and backend_TOP,
// with flush and complete-instruction accounting.
module uop_issue_queue #(
    parameter int NUM_UOPS      = 128,
    parameter int XLEN          = 32,
    parameter int ARCHFILE_SIZE = 16,
    parameter int QDEPTH        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dec_valid,
    output logic                             dec_ready,
    input  logic [$clog2(NUM_UOPS)-1:0]      dec_uop,
    input  logic                             dec_eoi,
    input  logic [XLEN-1:0]                  dec_imm,
    input  logic                             dec_use_imm,
    input  logic [31:0]                      dec_pc,
    input  logic                             dec_except,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_src1_arch,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_src2_arch,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_dest_arch,
    input  logic                             be_stall,
    input  logic                             flush,
    output logic                             uop_ready,
    output logic [$clog2(NUM_UOPS)-1:0]      uop,
    output logic                             eoi,
    output logic [XLEN-1:0]                  imm,
    output logic                             use_imm,
    output logic [31:0]                      pc,
    output logic                             except,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] src1_arch,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] src2_arch,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] dest_arch,
    output logic [$clog2(QDEPTH):0]          count,
    output logic [$clog2(QDEPTH):0]          inst_count
);

    import uop_pkg::*;

    localparam int IW = $clog2(QDEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [PW-1:0]      r_count;
    logic [PW-1:0]      r_inst_count;

    logic               w_empty;
    logic               w_full;
    logic               w_enq;
    logic               w_deq;
    uop_entry_t         w_wr;
    uop_entry_t         w_rd;
    uop_entry_t         w_head;
    logic [ENTRY_W-1:0] w_rd_bits;
    logic [PW-1:0]      w_inst_add;
    logic [PW-1:0]      w_inst_sub;

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[IW-1:0] == r_tail[IW-1:0])
                  && (r_head[IW] != r_tail[IW]);

    // Full is strict: a same-cycle dequeue does not free a slot.
    assign w_enq = dec_valid && !w_full && !flush;
    assign w_deq = !w_empty && !be_stall && !flush;

    assign w_wr = '{
        uop:       dec_uop,
        eoi:       dec_eoi,
        imm:       dec_imm,
        use_imm:   dec_use_imm,
        pc:        dec_pc,
        except:    dec_except,
        src1_arch: dec_src1_arch,
        src2_arch: dec_src2_arch,
        dest_arch: dec_dest_arch
    };

    uop_fifo_mem #(
        .DEPTH (QDEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_tail[IW-1:0]),
        .i_wdata (pack_entry(w_wr)),
        .i_raddr (r_head[IW-1:0]),
        .o_rdata (w_rd_bits)
    );

    assign w_rd   = unpack_entry(w_rd_bits);
    assign w_head = w_empty ? '0 : w_rd;

    assign w_inst_add = PW'(w_enq && dec_eoi);
    assign w_inst_sub = PW'(w_deq && w_head.eoi);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_inst_count <= '0;
        end else if (flush) begin
            r_head       <= r_tail;
            r_count      <= '0;
            r_inst_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PW'(1);
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
            r_inst_count <= r_inst_count + w_inst_add - w_inst_sub;
        end
    end

    assign dec_ready  = !w_full;
    assign uop_ready  = !w_empty;
    assign uop        = w_head.uop;
    assign eoi        = w_head.eoi;
    assign imm        = w_head.imm;
    assign use_imm    = w_head.use_imm;
    assign pc         = w_head.pc;
    assign except     = w_head.except;
    assign src1_arch  = w_head.src1_arch;
    assign src2_arch  = w_head.src2_arch;
    assign dest_arch  = w_head.dest_arch;
    assign count      = r_count;
    assign inst_count = r_inst_count;

endmodule
